// File: rtl/flag_branch_unit.sv
// flag_branch_unit: architectural Z/V/N flags, in-flight flag-writer tracking and
// hazard-aware conditional branch resolution with a req/ack handshake to fetch.
module flag_branch_unit #(
    parameter int PEND_MAX = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_alu_valid,
    input  logic [2:0]  i_alu_opcode,
    input  logic [2:0]  i_alu_flags,
    input  logic        i_fl_issue,
    input  logic        i_br_req,
    input  logic        i_br_type,
    input  logic [2:0]  i_br_ccc,
    input  logic [15:0] i_br_pc,
    input  logic [8:0]  i_br_imm,
    input  logic [15:0] i_br_reg,
    output logic        o_br_ack,
    output logic        o_br_taken,
    output logic [15:0] o_br_target,
    output logic        o_stall,
    output logic [2:0]  o_flags,
    output logic [1:0]  o_pend_cnt,
    output logic        o_err
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    localparam logic [1:0] CNT_MAX = PEND_MAX[1:0];

    state_t      r_state, w_next;
    logic [2:0]  r_flags, w_nflags;
    logic [1:0]  r_cnt, w_ncnt;
    logic        r_err, r_taken, w_err_set, w_writer, w_wvn, w_cond, w_resolve;
    logic [15:0] r_target, w_pc2, w_target;

    // Opcodes 011 and 111 leave the flags alone; only ADD/SUB touch V and N.
    always_comb begin
        w_writer  = i_alu_valid && i_alu_opcode[1:0] != 2'b11;
        w_wvn     = i_alu_valid && i_alu_opcode[2:1] == 2'b00;
        w_nflags  = {w_writer ? i_alu_flags[2] : r_flags[2], w_wvn ? i_alu_flags[1:0] : r_flags[1:0]};
        w_ncnt    = (i_fl_issue == w_writer) ? r_cnt :
                    i_fl_issue ? ((r_cnt == CNT_MAX) ? r_cnt : r_cnt + 2'd1) :
                    ((r_cnt == 2'd0) ? r_cnt : r_cnt - 2'd1);
        w_err_set = (i_fl_issue && !w_writer && r_cnt == CNT_MAX) ||
                    (w_writer && !i_fl_issue && r_cnt == 2'd0) ||
                    (i_fl_issue && r_state != IDLE);
    end

    always_comb begin
        w_cond = 1'b1;
        case (i_br_ccc)
            3'd0: w_cond = !w_nflags[2];
            3'd1: w_cond = w_nflags[2];
            3'd2: w_cond = !w_nflags[2] && !w_nflags[0];
            3'd3: w_cond = w_nflags[0];
            3'd4: w_cond = w_nflags[2] || !w_nflags[0];
            3'd5: w_cond = w_nflags[0] || w_nflags[2];
            3'd6: w_cond = w_nflags[1];
            default: w_cond = 1'b1;
        endcase
        w_pc2    = i_br_pc + 16'd2;
        w_target = !w_cond ? w_pc2 : i_br_type ? i_br_reg : w_pc2 + {{6{i_br_imm[8]}}, i_br_imm, 1'b0};
    end

    always_comb begin
        w_resolve = w_ncnt == 2'd0 && ((r_state == IDLE && i_br_req) || r_state == WAIT);
        w_next    = (r_state == RESP) ? IDLE :
                    w_resolve ? RESP :
                    (r_state == IDLE && i_br_req) ? WAIT : r_state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_flags  <= 3'b000;
            r_cnt    <= 2'd0;
            r_err    <= 1'b0;
            r_taken  <= 1'b0;
            r_target <= 16'h0000;
        end else begin
            r_state <= w_next;
            r_flags <= w_nflags;
            r_cnt   <= w_ncnt;
            r_err   <= r_err | w_err_set;
            if (w_resolve) begin
                r_taken  <= w_cond;
                r_target <= w_target;
            end
        end
    end

    assign o_br_ack    = r_state == RESP;
    assign o_br_taken  = r_taken;
    assign o_br_target = r_target;
    assign o_stall     = i_br_req && r_state != RESP;
    assign o_flags     = r_flags;
    assign o_pend_cnt  = r_cnt;
    assign o_err       = r_err;
endmodule

// File: tb/tb_flag_branch_unit.sv
// tb_flag_branch_unit: directed literal checks plus randomized traffic compared every
// cycle against a mask-table / integer-count reference model of the flag branch unit.
module tb_flag_branch_unit;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        alu_valid = 1'b0, fl_issue = 1'b0, br_req = 1'b0, br_type = 1'b0;
    logic [2:0]  alu_opcode = 3'd0, alu_flags = 3'd0, br_ccc = 3'd0;
    logic [15:0] br_pc = 16'd0, br_reg = 16'd0;
    logic [8:0]  br_imm = 9'd0;
    logic        o_br_ack, o_br_taken, o_stall, o_err;
    logic [15:0] o_br_target;
    logic [2:0]  o_flags;
    logic [1:0]  o_pend_cnt;

    flag_branch_unit dut (
        .clk(clk), .rst_n(rst_n), .i_alu_valid(alu_valid), .i_alu_opcode(alu_opcode),
        .i_alu_flags(alu_flags), .i_fl_issue(fl_issue), .i_br_req(br_req), .i_br_type(br_type),
        .i_br_ccc(br_ccc), .i_br_pc(br_pc), .i_br_imm(br_imm), .i_br_reg(br_reg),
        .o_br_ack(o_br_ack), .o_br_taken(o_br_taken), .o_br_target(o_br_target),
        .o_stall(o_stall), .o_flags(o_flags), .o_pend_cnt(o_pend_cnt), .o_err(o_err)
    );

    always #5 clk = ~clk;

    int n_pass = 0, n_tot = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // which flag bits {Z,V,N} each opcode is allowed to write
    localparam logic [2:0] MASK [8] = '{3'b111, 3'b111, 3'b100, 3'b000, 3'b100, 3'b100, 3'b100, 3'b000};

    function automatic bit cond(input logic [2:0] c, input logic [2:0] f);
        bit z, v, n;
        z = f[2]; v = f[1]; n = f[0];
        case (c)
            3'd0: return !z;
            3'd1: return z;
            3'd2: return !z && !n;
            3'd3: return n;
            3'd4: return z || (!z && !n);
            3'd5: return n || z;
            3'd6: return v;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [15:0] target(input bit tk, input bit ty, input int pc, input int imm, input int rg);
        int off;
        off = (imm >= 256) ? imm - 512 : imm;
        if (!tk) return 16'(pc + 2);
        if (ty) return 16'(rg);
        return 16'(pc + 2 + 2 * off);
    endfunction

    logic [2:0]  m_flags = 3'd0;
    int          m_cnt = 0;
    bit          m_err = 0, m_resp = 0, m_wait = 0, m_taken = 0;
    logic [15:0] m_target = 16'd0;

    always @(posedge clk or negedge rst_n) begin : model
        logic [2:0] mk, nf;
        int c;
        if (!rst_n) begin
            m_flags <= 3'd0; m_cnt <= 0; m_err <= 0; m_resp <= 0; m_wait <= 0;
            m_taken <= 0; m_target <= 16'd0;
        end else begin
            mk = alu_valid ? MASK[alu_opcode] : 3'b000;
            nf = (m_flags & ~mk) | (alu_flags & mk);
            c  = m_cnt + int'(fl_issue) - int'(mk != 3'b000);
            if (c < 0 || c > 3 || (fl_issue && (m_resp || m_wait))) m_err <= 1;
            c = (c < 0) ? 0 : (c > 3) ? 3 : c;
            m_flags <= nf;
            m_cnt   <= c;
            if (m_resp) m_resp <= 0;
            else if (br_req || m_wait) begin
                if (c == 0) begin
                    m_resp   <= 1;
                    m_wait   <= 0;
                    m_taken  <= cond(br_ccc, nf);
                    m_target <= target(cond(br_ccc, nf), br_type, int'(br_pc), int'(br_imm), int'(br_reg));
                end else m_wait <= 1;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("flags", int'(o_flags), int'(m_flags));
            chk("pend_cnt", int'(o_pend_cnt), m_cnt);
            chk("err", int'(o_err), int'(m_err));
            chk("br_ack", int'(o_br_ack), int'(m_resp));
            chk("stall", int'(o_stall), int'(br_req && !m_resp));
            chk("br_taken", int'(o_br_taken), int'(m_taken));
            chk("br_target", int'(o_br_target), int'(m_target));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic alu(input logic [2:0] op, input logic [2:0] f);
        alu_valid = 1'b1; alu_opcode = op; alu_flags = f;
    endtask

    task automatic br(input bit ty, input logic [2:0] c, input logic [15:0] pc, input logic [8:0] imm, input logic [15:0] rg);
        br_req = 1'b1; br_type = ty; br_ccc = c; br_pc = pc; br_imm = imm; br_reg = rg;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_flags", int'(o_flags), 0);
        chk("rst_target", int'(o_br_target), 0);
        fl_issue = 1'b1; cyc(); fl_issue = 1'b0;
        chk("issue_cnt", int'(o_pend_cnt), 1);
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_cnt", int'(o_pend_cnt), 0);
        chk("async_rst_ack", int'(o_br_ack), 0);
        cyc(); rst_n = 1'b1;
        fl_issue = 1'b1; cyc(); fl_issue = 1'b0;
        alu(3'd1, 3'b011); cyc(); alu_valid = 1'b0;
        chk("sub_flags", int'(o_flags), 3'b011);
        chk("sub_cnt", int'(o_pend_cnt), 0);
        fl_issue = 1'b1; cyc(); fl_issue = 1'b0;
        alu(3'd2, 3'b100); cyc(); alu_valid = 1'b0;
        chk("xor_flags", int'(o_flags), 3'b111);
        alu(3'd3, 3'b000); cyc(); alu_valid = 1'b0;
        chk("red_flags", int'(o_flags), 3'b111);
        chk("red_cnt", int'(o_pend_cnt), 0);
        br(1'b0, 3'd1, 16'h0100, 9'h1FF, 16'h0); #1;
        chk("beq_stall", int'(o_stall), 1);
        cyc();
        chk("beq_ack", int'(o_br_ack), 1);
        chk("beq_taken", int'(o_br_taken), 1);
        chk("beq_target", int'(o_br_target), 16'h0100);
        chk("beq_stall_resp", int'(o_stall), 0);
        br_req = 1'b0; cyc();
        chk("beq_ack_pulse", int'(o_br_ack), 0);
        chk("beq_taken_hold", int'(o_br_taken), 1);
        fl_issue = 1'b1; cyc(); fl_issue = 1'b0;
        br(1'b1, 3'd3, 16'h0200, 9'h0, 16'hBEEF);
        for (int i = 0; i < 3; i++) begin
            #1 chk("hz_stall", int'(o_stall), 1);
            cyc();
        end
        alu(3'd1, 3'b001); cyc(); alu_valid = 1'b0;
        chk("hz_ack", int'(o_br_ack), 1);
        chk("hz_taken", int'(o_br_taken), 1);
        chk("hz_target", int'(o_br_target), 16'hBEEF);
        br_req = 1'b0; cyc();
        fl_issue = 1'b1; cyc(); fl_issue = 1'b0;
        br(1'b1, 3'd3, 16'h0200, 9'h0, 16'hBEEF);
        alu(3'd1, 3'b000); cyc(); alu_valid = 1'b0;
        chk("fwd_ack", int'(o_br_ack), 1);
        chk("fwd_taken", int'(o_br_taken), 0);
        chk("fwd_target", int'(o_br_target), 16'h0202);
        br_req = 1'b0; cyc();
        br(1'b0, 3'd6, 16'hFFFE, 9'h005, 16'h0); cyc();
        chk("wrap_ack", int'(o_br_ack), 1);
        chk("wrap_taken", int'(o_br_taken), 0);
        chk("wrap_target", int'(o_br_target), 16'h0000);
        br_req = 1'b0; cyc();
        chk("err_clean", int'(o_err), 0);
        alu(3'd0, 3'b111); cyc(); alu_valid = 1'b0;
        chk("underflow_err", int'(o_err), 1);
        chk("underflow_cnt", int'(o_pend_cnt), 0);
        fl_issue = 1'b1; repeat (4) cyc(); fl_issue = 1'b0;
        chk("sat_cnt", int'(o_pend_cnt), 3);
        repeat (5) cyc();
        chk("err_sticky", int'(o_err), 1);
        br(1'b0, 3'd7, 16'h1000, 9'h004, 16'h0); cyc(); cyc();
        chk("wait_stall", int'(o_stall), 1);
        #3 rst_n = 1'b0;
        #1;
        chk("rstw_ack", int'(o_br_ack), 0);
        chk("rstw_err", int'(o_err), 0);
        chk("rstw_cnt", int'(o_pend_cnt), 0);
        chk("rstw_stall", int'(o_stall), 1);
        @(posedge clk); #1 rst_n = 1'b1; br_req = 1'b0;
        cyc(); chk("rstw_no_ack", int'(o_br_ack), 0);
        cyc(); chk("rstw_no_ack2", int'(o_br_ack), 0);
        for (int k = 0; k < 1500; k++) begin
            if (br_req && o_br_ack) br_req = 1'b0;
            else if (!br_req && !m_resp && $urandom_range(3) == 0)
                br(1'($urandom_range(1)), 3'($urandom_range(7)), 16'($urandom), 9'($urandom), 16'($urandom));
            fl_issue   = !br_req && !m_resp && !m_wait && m_cnt < 3 && $urandom_range(2) == 0;
            alu_valid  = 1'($urandom_range(1));
            alu_opcode = 3'($urandom_range(7));
            alu_flags  = 3'($urandom_range(7));
            if (alu_valid && m_cnt == 0 && alu_opcode[1:0] != 2'b11) alu_opcode[1:0] = 2'b11;
            cyc();
        end
        alu_valid = 1'b0; fl_issue = 1'b0; br_req = 1'b0;
        repeat (3) cyc();
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule

// File: doc/flag_branch_unit.md
# flag_branch_unit

Consumer end of the ALU result/flag interface in the 16-bit pipelined core. Holds the architectural Z/V/N flag register, applies per-opcode flag write masks to ALU results, and tracks in-flight flag-writing instructions. Resolves conditional branches (B/BR) only after every older flag writer has retired, and returns taken/target to fetch through a request/acknowledge handshake.

## Interface
- PEND_MAX, 3, maximum in-flight flag writers; the counter is 2 bits wide.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- alu_valid  in  1  ALU result retiring this cycle.
- alu_opcode  in  3  opcode of the retiring ALU op.
- alu_flags  in  3  flags of the retiring op: [2]=Z, [1]=V, [0]=N.
- fl_issue  in  1  decode issued a flag-writing op this cycle.
- br_req  in  1  branch resolution request; held high with br_* stable until br_ack.
- br_type  in  1  0 = B (PC-relative), 1 = BR (register).
- br_ccc  in  3  condition code.
- br_pc  in  16  address of the branch.
- br_imm  in  9  signed word offset (B only).
- br_reg  in  16  register target (BR only).
- br_ack  out  1  one-cycle pulse; branch resolved.
- br_taken  out  1  valid with br_ack.
- br_target  out  16  next PC; valid with br_ack.
- stall  out  1  br_req is high and the branch is not yet resolved.
- flags  out  3  architectural flag register.
- pend_cnt  out  2  in-flight flag writers.
- err  out  1  sticky protocol error.

## Operation
- Flag write mask, applied on alu_valid:
  - 000 ADD, 001 SUB: write Z, V, N.
  - 010 XOR, 100 SLL, 101 SRA, 110 ROR: write Z only.
  - 011 RED, 111 PADDSUB: write none.
- A flag writer is alu_valid with an opcode other than 011 or 111.
- pend_cnt update:
  - +1 on fl_issue; −1 on flag-writer retire; both in one cycle leaves it unchanged.
  - Decrement at 0: err is set and the count stays 0.
  - Increment at PEND_MAX: err is set and the count saturates.
- fl_issue while the FSM is not IDLE sets err and is still counted.
- err clears only on reset.
- nflags and ncnt are this cycle's next-state flag and count values, including same-cycle retirement (forwarding).
- Conditions, evaluated on nflags:
  - 000 NE: Z=0.
  - 001 EQ: Z=1.
  - 010 GT: Z=0 and N=0.
  - 011 LT: N=1.
  - 100 GE: Z=1 or (Z=0 and N=0).
  - 101 LE: N=1 or Z=1.
  - 110 OV: V=1.
  - 111 always.
- Target:
  - Not taken: br_pc+2.
  - B taken: br_pc + 2 + (sext(br_imm) << 1).
  - BR taken: br_reg.
  - All arithmetic is modulo 2^16, with wrap-around permitted.
- FSM:
  - IDLE: br_req with ncnt==0 → RESP (taken/target registered). br_req with ncnt>0 → WAIT.
  - WAIT: ncnt==0 → RESP (taken/target registered from nflags). Otherwise stay in WAIT.
  - RESP: br_ack=1 for one cycle → IDLE. br_req is ignored in RESP.
- stall = br_req & (state != RESP).

## Timing
- Reset values: state IDLE, flags 000, pend_cnt 0, err 0, br_ack 0, br_taken 0, br_target 0x0000. stall follows br_req.
- Asynchronous reset mid-WAIT or mid-RESP returns to IDLE immediately. No br_ack is produced.
- flags and pend_cnt update on the clock edge after alu_valid / fl_issue.
- Branch latency: br_ack rises one cycle after the cycle in which ncnt==0 is seen with br_req high. Minimum is 1 cycle from br_req.
- If the last pending writer retires in the same cycle as br_req, its flags are used (forwarded). Resolution takes 1 cycle.
- br_taken and br_target hold their values after br_ack until the next resolution.

## Test plan
- Reset: assert rst_n=0 asynchronously mid-cycle → all outputs at their reset values immediately. Release → IDLE.
- Flag masking:
  - SUB with alu_flags=011 (fl_issue first) → flags=011.
  - XOR with alu_flags=100 → flags=111.
  - RED with alu_flags=000 → flags=111, and pend_cnt is unchanged by RED.
- B EQ, no pending: flags Z=1, br_pc=0x0100, br_imm=0x1FF → next cycle br_ack=1, br_taken=1, br_target=0x0100.
- Hazard:
  - fl_issue once, then BR LT with br_reg=0xBEEF → stall=1 for 3 cycles.
  - SUB retires with alu_flags=001 → next cycle br_ack=1, taken=1, target=0xBEEF.
  - Repeat with retire in the br_req cycle → ack after 1 cycle.
- Not taken with wrap-around: flags V=0, ccc=110, br_pc=0xFFFE → br_taken=0, br_target=0x0000.
- Errors:
  - ADD retire with pend_cnt=0 → err=1, pend_cnt=0.
  - 4 fl_issue → pend_cnt=3, err=1.
  - err stays high until rst_n is asserted.
  - Reset during WAIT → no br_ack.
